// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// State, opcode/funct and ALU operation constants live here.
package mcu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_R,
    CL_LW,
    CL_SW,
    CL_ADDI,
    CL_BEQ
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [5:0] ALU_ADD = 6'b000010;
  localparam logic [5:0] ALU_SUB = 6'b000110;
  localparam logic [5:0] ALU_AND = 6'b000000;
  localparam logic [5:0] ALU_OR  = 6'b000001;
  localparam logic [5:0] ALU_XOR = 6'b001100;
  localparam logic [5:0] ALU_SLT = 6'b000111;

  typedef struct packed {
    iclass_t    cls;
    logic [5:0] alu_op;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction decoder.
// Maps opcode/funct to instruction class, ALU op and legality.
module mcu_decode
  import mcu_pkg::*;
(
  input  logic [5:0] opc,
  input  logic [5:0] fn,
  output dec_t       dec
);

  always_comb begin
    dec.cls    = CL_R;
    dec.alu_op = ALU_ADD;
    dec.legal  = 1'b1;
    unique case (1'b1)
      (opc == OP_RTYPE): begin
        dec.cls = CL_R;
        unique case (fn)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_XOR:  dec.alu_op = ALU_XOR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: dec.legal  = 1'b0;
        endcase
      end
      (opc == OP_LW):   dec.cls = CL_LW;
      (opc == OP_SW):   dec.cls = CL_SW;
      (opc == OP_ADDI): dec.cls = CL_ADDI;
      (opc == OP_BEQ): begin
        dec.cls    = CL_BEQ;
        dec.alu_op = ALU_SUB;
      end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with stall
// timeout, illegal-opcode trap and retired-instruction counter.
module multicycle_control
  import mcu_pkg::*;
#(
  parameter int ALUOP_W = 6,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [31:0]        instruction,
  input  logic               mem_ready,
  input  logic               alu_zero,
  input  logic               trap_clear,
  output logic               pc_write,
  output logic               pc_src,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic [REG_AW-1:0]  read_sel_a,
  output logic [REG_AW-1:0]  read_sel_b,
  output logic [REG_AW-1:0]  write_sel,
  output logic               illegal,
  output logic               timeout,
  output logic               busy,
  output logic [CNT_W-1:0]   retired_cnt
);

  localparam int SC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          state, state_n;
  logic [31:0]     ir;
  logic [SC_W-1:0] stall_cnt;
  dec_t            dec;
  logic            waiting;
  logic            to_hit;
  logic            retire;
  logic            unused_bits;

  assign unused_bits = ^ir[10:6];

  mcu_decode u_dec (
    .opc (ir[31:26]),
    .fn  (ir[5:0]),
    .dec (dec)
  );

  assign waiting = (state == FETCH || state == MEM) && !mem_ready;

  // A waiting cycle that would bring the stall count up to TIMEOUT traps.
  assign to_hit = (TIMEOUT != 0) &&
                  (stall_cnt == SC_W'(TIMEOUT - 1));

  assign retire = (state == EXEC && dec.cls == CL_BEQ) ||
                  (state == MEM && mem_ready && dec.cls == CL_SW) ||
                  (state == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir          <= '0;
      stall_cnt   <= '0;
      retired_cnt <= '0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (state == FETCH && mem_ready) begin
        ir <= instruction;
      end
      if (waiting) begin
        stall_cnt <= stall_cnt + SC_W'(1);
      end else begin
        stall_cnt <= '0;
      end
      if (retire) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
      if (state == TRAP && trap_clear) begin
        illegal <= 1'b0;
        timeout <= 1'b0;
      end else begin
        if (state == DECODE && !dec.legal) begin
          illegal <= 1'b1;
        end
        if (waiting && to_hit) begin
          timeout <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (run) state_n = FETCH;
      end
      FETCH: begin
        if (mem_ready)   state_n = DECODE;
        else if (to_hit) state_n = TRAP;
      end
      DECODE: begin
        state_n = dec.legal ? EXEC : TRAP;
      end
      EXEC: begin
        unique case (dec.cls)
          CL_LW, CL_SW: state_n = MEM;
          CL_BEQ:       state_n = run ? FETCH : IDLE;
          default:      state_n = WB;
        endcase
      end
      MEM: begin
        if (mem_ready) begin
          if (dec.cls == CL_LW) state_n = WB;
          else state_n = run ? FETCH : IDLE;
        end else if (to_hit) begin
          state_n = TRAP;
        end
      end
      WB: begin
        state_n = run ? FETCH : IDLE;
      end
      TRAP: begin
        if (trap_clear) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    unique case (state)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      EXEC: begin
        alu_op = ALUOP_W'(dec.alu_op);
        unique case (dec.cls)
          CL_R: alu_src = 1'b0;
          CL_BEQ: begin
            pc_src   = 1'b1;
            pc_write = alu_zero;
          end
          default: alu_src = 1'b1;
        endcase
      end
      MEM: begin
        mem_read  = (dec.cls == CL_LW);
        mem_write = (dec.cls == CL_SW);
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (dec.cls == CL_R);
        mem_to_reg = (dec.cls == CL_LW);
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE) && (state != TRAP);

  assign read_sel_a = busy ? ir[21 +: REG_AW] : '0;
  assign read_sel_b = busy ? ir[16 +: REG_AW] : '0;
  assign write_sel  = !busy  ? '0 :
                      reg_dst ? ir[11 +: REG_AW] :
                                ir[16 +: REG_AW];

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table
// plus hand sequences for trap, timeout and reset corners.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] instruction = '0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic        trap_clear = 1'b0;
  logic        pc_write, pc_src, ir_write, mem_read, mem_write;
  logic        alu_src, reg_dst, mem_to_reg, reg_write;
  logic [5:0]  alu_op;
  logic [4:0]  read_sel_a, read_sel_b, write_sel;
  logic        illegal, timeout, busy;
  logic [31:0] retired_cnt;
  logic [8:0]  ctl;

  int checks = 0;
  int errors = 0;

  multicycle_control #(
    .ALUOP_W (6),
    .REG_AW  (5),
    .TIMEOUT (4),
    .CNT_W   (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .instruction (instruction),
    .mem_ready   (mem_ready),
    .alu_zero    (alu_zero),
    .trap_clear  (trap_clear),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .ir_write    (ir_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .read_sel_a  (read_sel_a),
    .read_sel_b  (read_sel_b),
    .write_sel   (write_sel),
    .illegal     (illegal),
    .timeout     (timeout),
    .busy        (busy),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_write, pc_src, ir_write, mem_read, mem_write,
                alu_src, reg_dst, mem_to_reg, reg_write};

  localparam logic [8:0] C_NONE  = 9'b000000000;
  localparam logic [8:0] C_F_RDY = 9'b101100000;
  localparam logic [8:0] C_F_WT  = 9'b000100000;
  localparam logic [8:0] C_EX_I  = 9'b000001000;
  localparam logic [8:0] C_BEQ1  = 9'b110000000;
  localparam logic [8:0] C_BEQ0  = 9'b010000000;
  localparam logic [8:0] C_M_LW  = 9'b000100000;
  localparam logic [8:0] C_M_SW  = 9'b000010000;
  localparam logic [8:0] C_WB_R  = 9'b000000101;
  localparam logic [8:0] C_WB_I  = 9'b000000001;
  localparam logic [8:0] C_WB_LW = 9'b000000011;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_ADDI = 32'h20250007;
  localparam logic [31:0] I_SW   = 32'hAC220008;
  localparam logic [31:0] I_XOR  = 32'h00A62026;
  localparam logic [31:0] I_SLT  = 32'h0022382A;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  typedef struct {
    logic        run;
    logic        rdy;
    logic        zero;
    logic [31:0] ins;
    logic [8:0]  ctl;
    logic [5:0]  op;
    logic [4:0]  wsel;
    logic        busy;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic z,
                     input logic [31:0] ins, input logic [8:0] c,
                     input logic [5:0] op, input logic [4:0] ws,
                     input logic b, input logic [31:0] n);
    vec_t v;
    v.run = r; v.rdy = rdy; v.zero = z; v.ins = ins;
    v.ctl = c; v.op = op; v.wsel = ws; v.busy = b; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic z,
                     input logic clr, input logic [31:0] ins);
    @(negedge clk);
    run = r; mem_ready = rdy; alu_zero = z;
    trap_clear = clr; instruction = ins;
    #1;
  endtask

  initial begin
    // IDLE, then ADD (4 cycles)
    add(0, 0, 0, 0,      C_NONE,  6'b000000, 0, 0, 0);
    add(1, 0, 0, 0,      C_NONE,  6'b000000, 0, 0, 0);
    add(1, 1, 0, I_ADD,  C_F_RDY, 6'b000000, 0, 1, 0);
    add(1, 0, 0, 0,      C_NONE,  6'b000000, 2, 1, 0);
    add(1, 0, 0, 0,      C_NONE,  6'b000010, 2, 1, 0);
    add(1, 0, 0, 0,      C_WB_R,  6'b000000, 3, 1, 0);
    // LW with three wait cycles in MEM
    add(1, 1, 0, I_LW,   C_F_RDY, 6'b000000, 2, 1, 1);
    add(1, 0, 0, 0,      C_NONE,  6'b000000, 2, 1, 1);
    add(1, 0, 0, 0,      C_EX_I,  6'b000010, 2, 1, 1);
    add(1, 0, 0, 0,      C_M_LW,  6'b000000, 2, 1, 1);
    add(1, 0, 0, 0,      C_M_LW,  6'b000000, 2, 1, 1);
    add(1, 0, 0, 0,      C_M_LW,  6'b000000, 2, 1, 1);
    add(1, 1, 0, 0,      C_M_LW,  6'b000000, 2, 1, 1);
    add(1, 0, 0, 0,      C_WB_LW, 6'b000000, 2, 1, 1);
    // BEQ taken, then not taken
    add(1, 1, 0, I_BEQ,  C_F_RDY, 6'b000000, 2, 1, 2);
    add(1, 0, 0, 0,      C_NONE,  6'b000000, 2, 1, 2);
    add(1, 0, 1, 0,      C_BEQ1,  6'b000110, 2, 1, 2);
    add(1, 1, 0, I_BEQ,  C_F_RDY, 6'b000000, 2, 1, 3);
    add(1, 0, 0, 0,      C_NONE,  6'b000000, 2, 1, 3);
    add(1, 0, 0, 0,      C_BEQ0,  6'b000110, 2, 1, 3);
    // ADDI
    add(1, 1, 0, I_ADDI, C_F_RDY, 6'b000000, 2, 1, 4);
    add(1, 0, 0, 0,      C_NONE,  6'b000000, 5, 1, 4);
    add(1, 0, 0, 0,      C_EX_I,  6'b000010, 5, 1, 4);
    add(1, 0, 0, 0,      C_WB_I,  6'b000000, 5, 1, 4);
    // SW with run dropped in EXEC
    add(1, 1, 0, I_SW,   C_F_RDY, 6'b000000, 5, 1, 5);
    add(1, 0, 0, 0,      C_NONE,  6'b000000, 2, 1, 5);
    add(0, 0, 0, 0,      C_EX_I,  6'b000010, 2, 1, 5);
    add(0, 1, 0, 0,      C_M_SW,  6'b000000, 2, 1, 5);
    add(0, 0, 0, 0,      C_NONE,  6'b000000, 0, 0, 6);
    // XOR then SLT, stop after SLT
    add(1, 0, 0, 0,      C_NONE,  6'b000000, 0, 0, 6);
    add(1, 1, 0, I_XOR,  C_F_RDY, 6'b000000, 2, 1, 6);
    add(1, 0, 0, 0,      C_NONE,  6'b000000, 6, 1, 6);
    add(1, 0, 0, 0,      C_NONE,  6'b001100, 6, 1, 6);
    add(1, 0, 0, 0,      C_WB_R,  6'b000000, 4, 1, 6);
    add(1, 1, 0, I_SLT,  C_F_RDY, 6'b000000, 6, 1, 7);
    add(1, 0, 0, 0,      C_NONE,  6'b000000, 2, 1, 7);
    add(1, 0, 0, 0,      C_NONE,  6'b000111, 2, 1, 7);
    add(0, 0, 0, 0,      C_WB_R,  6'b000000, 7, 1, 7);
    add(0, 0, 0, 0,      C_NONE,  6'b000000, 0, 0, 8);

    repeat (2) @(negedge clk);
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst ctl", 32'(ctl), 0);
    chk("rst cnt", retired_cnt, 0);
    chk("rst illegal", 32'(illegal), 0);
    chk("rst timeout", 32'(timeout), 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].run, vecs[i].rdy, vecs[i].zero, 1'b0, vecs[i].ins);
      chk($sformatf("row%0d ctl", i), 32'(ctl), 32'(vecs[i].ctl));
      chk($sformatf("row%0d alu_op", i), 32'(alu_op), 32'(vecs[i].op));
      chk($sformatf("row%0d wsel", i), 32'(write_sel),
          32'(vecs[i].wsel));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("row%0d cnt", i), retired_cnt, vecs[i].cnt);
    end

    // illegal opcode trap and clear
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, I_BAD);
    cyc(1, 0, 0, 0, 0);
    chk("ill decode busy", 32'(busy), 1);
    chk("ill decode flag", 32'(illegal), 0);
    cyc(0, 0, 0, 0, 0);
    chk("ill trap flag", 32'(illegal), 1);
    chk("ill trap busy", 32'(busy), 0);
    chk("ill trap ctl", 32'(ctl), 0);
    chk("ill trap op", 32'(alu_op), 0);
    chk("ill trap rsa", 32'(read_sel_a), 0);
    chk("ill trap cnt", retired_cnt, 8);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("ill clr flag", 32'(illegal), 0);
    chk("ill clr busy", 32'(busy), 0);
    chk("ill clr cnt", retired_cnt, 8);

    // FETCH stall timeout after four stall cycles
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0, 0);
      chk($sformatf("to stall%0d ctl", k), 32'(ctl), 32'(C_F_WT));
      chk($sformatf("to stall%0d flag", k), 32'(timeout), 0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("to trap flag", 32'(timeout), 1);
    chk("to trap rd", 32'(mem_read), 0);
    chk("to trap busy", 32'(busy), 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("to clr flag", 32'(timeout), 0);

    // mem_ready on the fourth stall cycle completes the fetch
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, I_ADD);
    chk("late rdy irw", 32'(ir_write), 1);
    cyc(1, 0, 0, 0, 0);
    chk("late rdy busy", 32'(busy), 1);
    chk("late rdy flag", 32'(timeout), 0);
    cyc(1, 0, 0, 0, 0);
    chk("late rdy exec op", 32'(alu_op), 32'(6'b000010));
    cyc(1, 0, 0, 0, 0);
    chk("late rdy wb", 32'(ctl), 32'(C_WB_R));

    // async reset during SW in MEM
    cyc(1, 1, 0, 0, I_SW);
    chk("sw cnt", retired_cnt, 9);
    cyc(1, 0, 0, 0, 0);
    chk("sw rsa", 32'(read_sel_a), 1);
    chk("sw rsb", 32'(read_sel_b), 2);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("sw mem wr", 32'(mem_write), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 0);
    chk("arst mem wr", 32'(mem_write), 0);
    chk("arst cnt", retired_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    mem_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
